// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types, default depths and helpers for mem_access_unit.
package mem_access_pkg;
  typedef enum logic [1:0] {REG_M1 = 2'b00, REG_M2 = 2'b01, REG_M3 = 2'b10, REG_NONE = 2'b11} region_e;
  typedef enum logic [2:0] {IDLE, ISSUE, M2_SEQ, WAIT, RESP} state_e;
  localparam int M1_DEPTH_DEF = 1038;
  localparam int M2_DEPTH_DEF = 4096;
  localparam int M3_DEPTH_DEF = 3072;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam int LANE_W = 2;
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [LANE_W-1:0] l);
    return w[{l, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/mem_region_decode.sv
// mem_region_decode: maps a byte address and size to region, bank index, lane and error.
// Without MEM_ACCESS_M2_WORD_EN, M2 word accesses decode as errors.
module mem_region_decode
  import mem_access_pkg::*;
#(
  parameter int M1_DEPTH = M1_DEPTH_DEF,
  parameter int M2_DEPTH = M2_DEPTH_DEF,
  parameter int M3_DEPTH = M3_DEPTH_DEF
) (
  input  logic [15:0]       addr,
  input  logic              size,
  output region_e           region,
  output logic [11:0]       index,
  output logic [LANE_W-1:0] lane,
  output logic              err
);
  logic [13:0] idx_full;
  logic bad_align, bad_depth, bad_size;
  assign region = region_e'(addr[15:14]);
  assign lane = addr[1:0];
  assign idx_full = region == REG_M2 ? addr[13:0] : {2'b00, addr[13:2]};
  assign index = idx_full[11:0];
  assign bad_align = size == SIZE_WORD && addr[1:0] != 2'b00;
  assign bad_depth = region == REG_M1 ? 32'(idx_full) >= M1_DEPTH :
                     region == REG_M2 ? 32'(idx_full) >= M2_DEPTH :
                     region == REG_M3 ? 32'(idx_full) >= M3_DEPTH : 1'b1;
`ifdef MEM_ACCESS_M2_WORD_EN
  assign bad_size = 1'b0;
`else
  assign bad_size = region == REG_M2 && size == SIZE_WORD;
`endif
  assign err = bad_align || bad_depth || bad_size;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: request front end for the banked M1/M2/M3 data memory.
// Defining MEM_ACCESS_M2_WORD_EN builds the 4-beat M2 word sequencer.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int M1_DEPTH = M1_DEPTH_DEF,
  parameter int M2_DEPTH = M2_DEPTH_DEF,
  parameter int M3_DEPTH = M3_DEPTH_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_size,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [10:0] m1_address,
  output logic [31:0] m1_data,
  output logic [3:0]  m1_wren,
  input  logic [31:0] m1_q,
  output logic [11:0] m2_address,
  output logic [7:0]  m2_data,
  output logic        m2_wren,
  input  logic [7:0]  m2_q,
  output logic [11:0] m3_address,
  output logic [31:0] m3_data,
  output logic [3:0]  m3_wren,
  input  logic [31:0] m3_q
);
  state_e state, state_n;
  region_e dec_region, r_region;
  logic [11:0] dec_index;
  logic [LANE_W-1:0] dec_lane, r_lane;
  logic dec_err, r_err, r_we, r_size, accept, seq_go, go;
  logic [3:0] wmask;
  logic [31:0] lane_wdata, lane_q, m2_word, rdata_n;
  mem_region_decode #(.M1_DEPTH(M1_DEPTH), .M2_DEPTH(M2_DEPTH), .M3_DEPTH(M3_DEPTH)) u_dec (
    .addr(req_addr), .size(req_size), .region(dec_region), .index(dec_index), .lane(dec_lane), .err(dec_err)
  );
  assign accept = req_valid && req_ready;
  assign go = accept && !dec_err;
  assign wmask = req_size == SIZE_WORD ? 4'hf : 4'b0001 << dec_lane;
  assign lane_wdata = req_size == SIZE_WORD ? req_wdata : {4{req_wdata[7:0]}};
  assign lane_q = r_region == REG_M3 ? m3_q : m1_q;
  assign rsp_valid = state == RESP;
`ifdef MEM_ACCESS_M2_WORD_EN
  logic [1:0] beat;
  logic [23:0] seq_wdata, m2_acc;
  assign seq_go = go && dec_region == REG_M2 && req_size == SIZE_WORD;
  assign m2_word = {m2_q, m2_acc};
  // m2_acc shifts in bytes 0..2 as they return; byte 3 is still on m2_q at the final capture
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      beat <= 2'd0;
      seq_wdata <= '0;
      m2_acc <= '0;
    end else begin
      beat <= state == M2_SEQ ? beat + 2'd1 : 2'd0;
      seq_wdata <= accept ? req_wdata[31:8] : state == M2_SEQ ? seq_wdata >> 8 : seq_wdata;
      m2_acc <= state == M2_SEQ && beat != 2'd0 ? {m2_q, m2_acc[23:8]} : m2_acc;
    end
`else
  assign seq_go = 1'b0;
  assign m2_word = {24'd0, m2_q};
`endif
  assign rdata_n = r_err || r_we ? '0 :
                   r_size == SIZE_WORD ? (r_region == REG_M2 ? m2_word : lane_q) :
                   {24'd0, r_region == REG_M2 ? m2_q : lane_byte(lane_q, r_lane)};
  // Errors spend one no-access cycle in ISSUE so every response leaves at least one edge after acceptance
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = accept ? (seq_go ? M2_SEQ : ISSUE) : IDLE;
      ISSUE:  state_n = r_we || r_err ? RESP : WAIT;
`ifdef MEM_ACCESS_M2_WORD_EN
      M2_SEQ: state_n = beat == 2'd3 ? (r_we ? RESP : WAIT) : M2_SEQ;
`endif
      WAIT:   state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      req_ready <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      r_region <= REG_M1;
      r_lane <= '0;
      r_err <= 1'b0;
      r_we <= 1'b0;
      r_size <= 1'b0;
      m1_address <= '0;
      m1_data <= '0;
      m1_wren <= '0;
      m2_address <= '0;
      m2_data <= '0;
      m2_wren <= 1'b0;
      m3_address <= '0;
      m3_data <= '0;
      m3_wren <= '0;
    end else begin
      state <= state_n;
      req_ready <= state_n == IDLE;
      rsp_err <= state_n == RESP && r_err;
      rsp_rdata <= state_n == RESP ? rdata_n : '0;
      m1_wren <= '0;
      m2_wren <= 1'b0;
      m3_wren <= '0;
      if (accept) begin
        r_region <= dec_region;
        r_lane <= dec_lane;
        r_err <= dec_err;
        r_we <= req_we;
        r_size <= req_size;
      end
      if (go && dec_region == REG_M1) begin
        m1_address <= dec_index[10:0];
        m1_data <= lane_wdata;
        m1_wren <= req_we ? wmask : '0;
      end
      if (go && dec_region == REG_M2) begin
        m2_address <= dec_index;
        m2_data <= req_wdata[7:0];
        m2_wren <= req_we;
      end
      if (go && dec_region == REG_M3) begin
        m3_address <= dec_index;
        m3_data <= lane_wdata;
        m3_wren <= req_we ? wmask : '0;
      end
`ifdef MEM_ACCESS_M2_WORD_EN
      if (state == M2_SEQ && beat != 2'd3) begin
        m2_address <= m2_address + 12'd1;
        m2_data <= seq_wdata[7:0];
        m2_wren <= r_we;
      end
`endif
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized bench for mem_access_unit against a byte-level memory model.
// Follows MEM_ACCESS_M2_WORD_EN the same way the design does.
module tb_mem_access_unit;
`ifdef MEM_ACCESS_M2_WORD_EN
  localparam bit M2W = 1'b1;
`else
  localparam bit M2W = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_size = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, m1_data, m3_data, m1_q, m3_q;
  logic [10:0] m1_address;
  logic [11:0] m2_address, m3_address;
  logic [7:0] m2_data, m2_q;
  logic [3:0] m1_wren, m3_wren;
  logic m2_wren;
  int tests = 0, fails = 0;
  always #5 clock = ~clock;
  mem_access_unit dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .m1_address(m1_address), .m1_data(m1_data),
    .m1_wren(m1_wren), .m1_q(m1_q), .m2_address(m2_address), .m2_data(m2_data), .m2_wren(m2_wren),
    .m2_q(m2_q), .m3_address(m3_address), .m3_data(m3_data), .m3_wren(m3_wren), .m3_q(m3_q)
  );
  // Physical RAMs with one-cycle read latency
  logic [31:0] ram1 [0:1037];
  logic [7:0]  ram2 [0:4095];
  logic [31:0] ram3 [0:3071];
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] w;
    w = o;
    for (int k = 0; k < 4; k++) if (m[k]) w[8*k +: 8] = n[8*k +: 8];
    return w;
  endfunction
  always @(posedge clock) begin
    if (m1_address < 11'd1038) begin
      if (m1_wren != 4'd0) ram1[m1_address] <= merge(ram1[m1_address], m1_data, m1_wren);
      m1_q <= ram1[m1_address];
    end else m1_q <= '0;
    if (m2_wren) ram2[m2_address] <= m2_data;
    m2_q <= ram2[m2_address];
    if (m3_address < 12'd3072) begin
      if (m3_wren != 4'd0) ram3[m3_address] <= merge(ram3[m3_address], m3_data, m3_wren);
      m3_q <= ram3[m3_address];
    end else m3_q <= '0;
  end
  // Write-strobe monitor
  int n1 = 0, n2 = 0, n3 = 0;
  logic [3:0] last1 = '0, last3 = '0;
  logic [10:0] last1_addr = '0;
  logic [31:0] last3_data = '0;
  always @(negedge clock) begin
    if (m1_wren != 4'd0) begin n1 <= n1 + 1; last1 <= m1_wren; last1_addr <= m1_address; end
    if (m2_wren) n2 <= n2 + 1;
    if (m3_wren != 4'd0) begin n3 <= n3 + 1; last3 <= m3_wren; last3_data <= m3_data; end
  end
  // Reference model: flat byte arrays per region, little-endian
  logic [7:0] ref1 [0:4151];
  logic [7:0] ref2 [0:4095];
  logic [7:0] ref3 [0:12287];
  function automatic logic [7:0] rb(input int r, input int off);
    return r == 0 ? ref1[off] : r == 1 ? ref2[off] : ref3[off];
  endfunction
  task automatic wb(input int r, input int off, input logic [7:0] v);
    if (r == 0) ref1[off] = v;
    else if (r == 1) ref2[off] = v;
    else ref3[off] = v;
  endtask
  function automatic logic exp_err(input logic sz, input logic [15:0] a);
    if (sz && a[1:0] != 2'b00) return 1'b1;
    case (a[15:14])
      2'b00: return a[13:2] >= 12'd1038;
      2'b01: return a[13:0] >= 14'd4096 || (sz && !M2W);
      2'b10: return a[13:2] >= 12'd3072;
      default: return 1'b1;
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_req(input logic we, input logic sz, input logic [15:0] a, input logic [31:0] wd);
    logic e;
    int r, off, lat, exp_lat, b1, b2, b3, exp_w;
    logic [31:0] exp_d;
    r = int'(a[15:14]);
    off = int'(a[13:0]);
    e = exp_err(sz, a);
    exp_d = '0;
    if (!e && !we) exp_d = sz ? {rb(r, off+3), rb(r, off+2), rb(r, off+1), rb(r, off)} : {24'd0, rb(r, off)};
    exp_lat = e ? 1 : (r == 1 && sz) ? (we ? 4 : 5) : (we ? 1 : 2);
    exp_w = (e || !we) ? 0 : r == 0 ? 256 : r == 2 ? 1 : sz ? 64 : 16;
    lat = 0;
    while (!req_ready && lat < 50) begin @(negedge clock); lat++; end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    b1 = n1; b2 = n2; b3 = n3;
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clock); @(negedge clock); lat++; end
    check("rsp_latency", lat, exp_lat);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, e});
    check("rsp_rdata", rsp_rdata, exp_d);
    @(negedge clock);
    check("rsp_single_pulse", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_back", {31'd0, req_ready}, 32'd1);
    check("wren_cycles", (n1 - b1) * 256 + (n2 - b2) * 16 + (n3 - b3), exp_w);
    if (!e && we && r == 0) check("m1_wren_mask", {28'd0, last1}, sz ? 32'hf : 32'd1 << a[1:0]);
    if (!e && we && r == 2) check("m3_wren_mask", {28'd0, last3}, sz ? 32'hf : 32'd1 << a[1:0]);
    if (!e && we) for (int k = 0; k < (sz ? 4 : 1); k++) wb(r, off + k, wd[8*k +: 8]);
  endtask
  function automatic int pick(input int d);
    return $urandom_range(0, 3) == 0 ? d - 6 + int'($urandom_range(0, 11)) : int'($urandom_range(0, 31));
  endfunction
  initial begin
    logic [31:0] w;
    logic [15:0] a;
    int r, idx, lo;
    logic we, sz;
    for (int i = 0; i < 1038; i++) begin
      w = $urandom; ram1[i] = w;
      for (int k = 0; k < 4; k++) ref1[i*4+k] = w[8*k +: 8];
    end
    for (int i = 0; i < 3072; i++) begin
      w = $urandom; ram3[i] = w;
      for (int k = 0; k < 4; k++) ref3[i*4+k] = w[8*k +: 8];
    end
    for (int i = 0; i < 4096; i++) begin
      w = $urandom; ram2[i] = w[7:0]; ref2[i] = w[7:0];
    end
    repeat (3) @(negedge clock);
    check("reset_ready", {31'd0, req_ready}, 32'd0);
    check("reset_rsp", {rsp_valid, rsp_err, 30'd0} | rsp_rdata, 32'd0);
    check("reset_wren", {23'd0, m1_wren, m2_wren, m3_wren}, 32'd0);
    check("reset_addr", {9'd0, m1_address, m2_address} | {20'd0, m3_address}, 32'd0);
    check("reset_data", m1_data | m3_data | {24'd0, m2_data}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("ready_after_release", {31'd0, req_ready}, 32'd1);
    do_req(1'b1, 1'b1, 16'h0010, 32'hdeadbeef);
    check("m1_address", {21'd0, last1_addr}, 32'd4);
    do_req(1'b0, 1'b1, 16'h0010, 32'h0);
    do_req(1'b0, 1'b0, 16'h0013, 32'h0);
    do_req(1'b1, 1'b1, 16'h4008, 32'h11223344);
    do_req(1'b0, 1'b1, 16'h4008, 32'h0);
    do_req(1'b0, 1'b0, 16'h400a, 32'h0);
    do_req(1'b0, 1'b1, 16'h1038, 32'h0);
    do_req(1'b1, 1'b1, 16'h4001, 32'h55aa55aa);
    do_req(1'b0, 1'b0, 16'hc000, 32'h0);
    do_req(1'b0, 1'b1, 16'hb000, 32'h0);
    do_req(1'b1, 1'b0, 16'h8006, 32'h000000a5);
    check("m3_lane_data", {24'd0, last3_data[23:16]}, 32'ha5);
    do_req(1'b0, 1'b1, 16'h8004, 32'h0);
    // Reset in the middle of an operation
    w = 32'hcafe1234;
    req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1; req_wdata = w;
    req_addr = M2W ? 16'h4020 : 16'h0040;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    if (M2W) begin
      @(posedge clock); @(negedge clock);
      @(posedge clock); @(negedge clock);
      check("m2_beat_active", {31'd0, m2_wren}, 32'd1);
    end else check("m1_wren_active", {28'd0, m1_wren}, 32'hf);
    reset_n = 1'b0;
    #1;
    check("reset_clears_wren", {23'd0, m1_wren, m2_wren, m3_wren}, 32'd0);
    check("reset_ready_low", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); @(negedge clock);
      check("no_rsp_in_reset", {31'd0, rsp_valid}, 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("ready_after_midop_reset", {31'd0, req_ready}, 32'd1);
    check("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);
    if (M2W) begin
      ref2[32] = w[7:0];
      ref2[33] = w[15:8];
      do_req(1'b0, 1'b1, 16'h4020, 32'h0);
    end else do_req(1'b0, 1'b1, 16'h0040, 32'h0);
    for (int t = 0; t < 300; t++) begin
      r = int'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      sz = 1'($urandom_range(0, 1));
      lo = (sz && $urandom_range(0, 3) != 0) ? 0 : int'($urandom_range(0, 3));
      a = 16'($urandom);
      a[15:14] = 2'(r);
      if (r == 0 || r == 2) begin
        idx = pick(r == 0 ? 1038 : 3072);
        a[13:2] = 12'(idx);
        a[1:0] = 2'(lo);
      end else if (r == 1) begin
        idx = pick(4096);
        a[13:0] = 14'(idx);
        if (lo == 0 && sz) a[1:0] = 2'b00;
      end
      do_req(we, sz, a, $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
